// File: rtl/obstacle_scheduler.sv
// -----------------------------------------------------------------------------
// obstacle_scheduler
//
// Owns the obstacle slot pool for the running level. It paces spawns with a
// cooldown counter, allocates the lowest free slot, picks a lane (1..3) from
// the LFSR value, steps every busy slot left on move_tick, and retires slots
// at the left edge. Every RAMP_EVERY retirements the scroll step grows by one,
// up to MAX_STEP.
//
// Configuration macro:
//   OBSTACLE_LANE_GUARD_EN - when defined, two consecutive allocations never
//                            share a lane (a previous-lane register is built).
//
// Ports:
//   CLK         in   system clock
//   RESET       in   asynchronous, active-high reset
//   game_run    in   level is in a running state
//   restart     in   1-cycle pulse: clear pool, speed and cooldown
//   hit         in   collision detected; freezes the scheduler until restart
//   spawn_tick  in   1-cycle pacing pulse (cooldown unit)
//   move_tick   in   1-cycle movement pulse
//   rand_val    in   13-bit LFSR value, sampled on allocation. Carries the
//                    LFSR "rand" signal; renamed because rand is a reserved
//                    word in SystemVerilog.
//   busy        out  per-slot active flag
//   slot_x      out  slot i X at [i*CORDW +: CORDW]
//   slot_loc    out  slot i lane at [2i +: 2], 0 when idle
//   spawn_pls   out  1-cycle pulse on each allocation
//   step        out  current pixels moved per move_tick
//   state_dbg   out  FSM state (0 IDLE, 1 RUN, 2 FROZEN)
//
// Handshake: there is no valid/ready flow here; every input is a level or a
// single-cycle pulse sampled on the rising CLK edge, and every output is
// registered, so an effect is visible one cycle after its trigger is sampled.
// -----------------------------------------------------------------------------
module obstacle_scheduler #(
    parameter int NSLOT      = 3,
    parameter int CORDW      = 10,
    parameter int SPAWN_X    = 700,
    parameter int RETIRE_X   = 80,
    parameter int COOLDOWN   = 18,
    parameter int RAMP_EVERY = 8,
    parameter int MAX_STEP   = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   game_run,
    input  logic                   restart,
    input  logic                   hit,
    input  logic                   spawn_tick,
    input  logic                   move_tick,
    input  logic [12:0]            rand_val,
    output logic [NSLOT-1:0]       busy,
    output logic [NSLOT*CORDW-1:0] slot_x,
    output logic [2*NSLOT-1:0]     slot_loc,
    output logic                   spawn_pls,
    output logic [2:0]             step,
    output logic [1:0]             state_dbg
);

    localparam int CDW = $clog2(COOLDOWN + 1);
    localparam int RCW = $clog2(RAMP_EVERY + NSLOT + 1);

    localparam logic [CDW-1:0]   CD_FULL  = CDW'(COOLDOWN);
    localparam logic [CORDW-1:0] X_SPAWN  = CORDW'(SPAWN_X);
    localparam logic [CORDW:0]   X_RETIRE = (CORDW + 1)'(RETIRE_X);
    localparam logic [RCW-1:0]   RC_WRAP  = RCW'(RAMP_EVERY);
    localparam logic [2:0]       STEP_MAX = 3'(MAX_STEP);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FROZEN = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   act;

    logic [CDW-1:0]         cd, cd_nxt;
    logic [RCW-1:0]         rc, rc_nxt;
    logic [RCW-1:0]         nret;
    logic [RCW-1:0]         rc_sum;
    logic [NSLOT-1:0]       busy_nxt;
    logic [NSLOT*CORDW-1:0] x_nxt;
    logic [2*NSLOT-1:0]     loc_nxt;
    logic                   pls_nxt;
    logic [2:0]             step_nxt;

    logic [NSLOT-1:0] alloc_oh;
    logic             do_alloc;
    logic [1:0]       lane_raw;
    logic [1:0]       lane_sel;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= S_IDLE;
        end else if (restart) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (game_run) state_nxt = S_RUN;
            S_RUN: begin
                if (hit)            state_nxt = S_FROZEN;
                else if (!game_run) state_nxt = S_IDLE;
            end
            S_FROZEN: state_nxt = S_FROZEN;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // The scheduler only acts in RUN, and not in a cycle that is leaving RUN
    // (hit or game_run dropping), so a hit freezes X on the very cycle it
    // arrives.
    always_comb begin
        act       = (state == S_RUN) && game_run && !hit;
        state_dbg = state;
    end

    // ---------------------------------------------------------------- lane
    assign lane_raw = 2'(rand_val % 13'd3) + 2'd1;

`ifdef OBSTACLE_LANE_GUARD_EN
    logic [1:0] prev_lane;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prev_lane <= 2'd0;
        end else if (restart) begin
            prev_lane <= 2'd0;
        end else if (do_alloc) begin
            prev_lane <= lane_sel;
        end
    end

    // Rotate to the next lane when the draw repeats the last one.
    assign lane_sel = (lane_raw == prev_lane) ? ((prev_lane == 2'd3) ? 2'd1 : prev_lane + 2'd1)
                                              : lane_raw;
`else
    assign lane_sel = lane_raw;
`endif

    // ---------------------------------------------------------------- pool
    // Lowest free slot as one-hot: ~busy & (busy + 1). Uses registered busy,
    // so a slot retiring this cycle is not reallocated until the next one.
    assign alloc_oh = ~busy & (busy + NSLOT'(1));
    assign do_alloc = act && (cd == CD_FULL) && (|(~busy));

    always_comb begin
        busy_nxt = busy;
        x_nxt    = slot_x;
        loc_nxt  = slot_loc;
        cd_nxt   = cd;
        rc_nxt   = rc;
        step_nxt = step;
        pls_nxt  = 1'b0;
        nret     = '0;
        rc_sum   = '0;

        if (act) begin
            // Allocation wins over a concurrent spawn_tick: cooldown lands on 0.
            if (do_alloc) begin
                cd_nxt  = '0;
                pls_nxt = 1'b1;
            end else if (spawn_tick && (cd != CD_FULL)) begin
                cd_nxt = cd + CDW'(1);
            end

            for (int i = 0; i < NSLOT; i++) begin
                if (do_alloc && alloc_oh[i]) begin
                    // Slot was idle at cycle start, so it is never moved here.
                    busy_nxt[i]             = 1'b1;
                    x_nxt[i*CORDW +: CORDW] = X_SPAWN;
                    loc_nxt[2*i +: 2]       = lane_sel;
                end else if (move_tick && busy[i]) begin
                    if ({1'b0, slot_x[i*CORDW +: CORDW]} >= X_RETIRE + {{(CORDW - 2){1'b0}}, step}) begin
                        x_nxt[i*CORDW +: CORDW] = slot_x[i*CORDW +: CORDW] - {{(CORDW - 3){1'b0}}, step};
                    end else begin
                        busy_nxt[i]             = 1'b0;
                        x_nxt[i*CORDW +: CORDW] = X_SPAWN;
                        loc_nxt[2*i +: 2]       = 2'd0;
                        nret                    = nret + RCW'(1);
                    end
                end
            end

            // Several slots may retire together; carry the excess past the
            // ramp boundary instead of dropping it.
            rc_sum = rc + nret;
            if (rc_sum >= RC_WRAP) begin
                rc_nxt = rc_sum - RC_WRAP;
                if (step < STEP_MAX) step_nxt = step + 3'd1;
            end else begin
                rc_nxt = rc_sum;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            busy      <= '0;
            slot_x    <= {NSLOT{X_SPAWN}};
            slot_loc  <= '0;
            spawn_pls <= 1'b0;
            step      <= 3'd1;
            cd        <= '0;
            rc        <= '0;
        end else if (restart) begin
            busy      <= '0;
            slot_x    <= {NSLOT{X_SPAWN}};
            slot_loc  <= '0;
            spawn_pls <= 1'b0;
            step      <= 3'd1;
            cd        <= '0;
            rc        <= '0;
        end else begin
            busy      <= busy_nxt;
            slot_x    <= x_nxt;
            slot_loc  <= loc_nxt;
            spawn_pls <= pls_nxt;
            step      <= step_nxt;
            cd        <= cd_nxt;
            rc        <= rc_nxt;
        end
    end

endmodule

// File: tb/tb_obstacle_scheduler.sv
module tb_obstacle_scheduler;

    localparam int NSLOT = 3;
    localparam int CORDW = 10;
    localparam int COOLDOWN = 18;

    logic                   CLK = 1'b0;
    logic                   RESET;
    logic                   game_run;
    logic                   restart;
    logic                   hit;
    logic                   spawn_tick;
    logic                   move_tick;
    logic [12:0]            rand_val;
    logic [NSLOT-1:0]       busy;
    logic [NSLOT*CORDW-1:0] slot_x;
    logic [2*NSLOT-1:0]     slot_loc;
    logic                   spawn_pls;
    logic [2:0]             step;
    logic [1:0]             state_dbg;

    int total = 0;
    int bad = 0;

    logic [1:0] exp_q[$];

    obstacle_scheduler dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .game_run   (game_run),
        .restart    (restart),
        .hit        (hit),
        .spawn_tick (spawn_tick),
        .move_tick  (move_tick),
        .rand_val   (rand_val),
        .busy       (busy),
        .slot_x     (slot_x),
        .slot_loc   (slot_loc),
        .spawn_pls  (spawn_pls),
        .step       (step),
        .state_dbg  (state_dbg)
    );

    // ------------------------------------------------------ clock / reset
    always #5 CLK = ~CLK;

    // ------------------------------------------------------ helpers
    function automatic logic [9:0] xo(input int i);
        return slot_x[i*CORDW +: CORDW];
    endfunction

    function automatic logic [1:0] lo(input int i);
        return slot_loc[2*i +: 2];
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // ------------------------------------------------------ driver tasks
    task automatic cyc(input logic st, input logic mt);
        spawn_tick = st;
        move_tick  = mt;
        @(posedge CLK);
        #1;
        spawn_tick = 1'b0;
        move_tick  = 1'b0;
    endtask

    task automatic cycn(input int n, input logic st, input logic mt);
        for (int k = 0; k < n; k++) cyc(st, mt);
    endtask

    typedef struct {
        logic [12:0] r;
        int          slot;
        logic [1:0]  lane;
        logic [2:0]  busy_after;
        int          moves_after;
    } alloc_vec_t;

    alloc_vec_t tbl[4];

    task automatic apply_alloc(input int i);
        rand_val = tbl[i].r;
        cycn(COOLDOWN, 1'b1, 1'b0);
        chk("pre_alloc_busy", busy, tbl[i].busy_after & ~(3'b001 << tbl[i].slot));
        cyc(1'b0, 1'b0);
        exp_q.push_back(tbl[i].lane);
        chk("alloc_busy", busy, tbl[i].busy_after);
        chk("alloc_loc", lo(tbl[i].slot), exp_q.pop_front());
        chk("alloc_x", xo(tbl[i].slot), 700);
        chk("alloc_pls", spawn_pls, 1);
        cyc(1'b0, 1'b0);
        chk("pls_one_cycle", spawn_pls, 0);
        cycn(tbl[i].moves_after, 1'b0, 1'b1);
    endtask

    // ------------------------------------------------------ main test
    logic [2:0]  pb;
    logic [9:0]  px[NSLOT];
    logic [1:0]  exp_lane;
    logic [1:0]  prev_lane_m;
    logic [12:0] r;
    int          sp;
    int          allocs;
    int          total_ret;
    int          exp_step;
    logic [2:0]  sb;
    logic [NSLOT*CORDW-1:0] sx;
    logic [2:0]  ss;

    initial begin
        tbl[0] = '{r: 13'd5, slot: 0, lane: 2'd3, busy_after: 3'b001, moves_after: 100};
        tbl[1] = '{r: 13'd4, slot: 1, lane: 2'd2, busy_after: 3'b011, moves_after: 0};
`ifdef OBSTACLE_LANE_GUARD_EN
        tbl[2] = '{r: 13'd4, slot: 0, lane: 2'd3, busy_after: 3'b011, moves_after: 0};
`else
        tbl[2] = '{r: 13'd4, slot: 0, lane: 2'd2, busy_after: 3'b011, moves_after: 0};
`endif
        tbl[3] = '{r: 13'd0, slot: 2, lane: 2'd1, busy_after: 3'b111, moves_after: 0};

        RESET = 1'b1;
        game_run = 1'b0;
        restart = 1'b0;
        hit = 1'b0;
        spawn_tick = 1'b0;
        move_tick = 1'b0;
        rand_val = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_x", slot_x, {10'd700, 10'd700, 10'd700});
        chk("rst_loc", slot_loc, 0);
        chk("rst_pls", spawn_pls, 0);
        chk("rst_step", step, 1);
        chk("rst_state", state_dbg, 0);
        RESET = 1'b0;

        // Enter RUN, then the first two allocations with a gap of movement.
        game_run = 1'b1;
        cyc(1'b0, 1'b0);
        chk("run_state", state_dbg, 1);
        apply_alloc(0);
        chk("x0_after_100", xo(0), 600);
        apply_alloc(1);

        // Slot0 walks down to the retire edge.
        cycn(518, 1'b0, 1'b1);
        chk("x0_at_82", xo(0), 82);
        chk("x1_at_182", xo(1), 182);
        cyc(1'b0, 1'b1);
        chk("x0_at_81", xo(0), 81);
        cyc(1'b0, 1'b1);
        chk("x0_at_80", xo(0), 80);
        cyc(1'b0, 1'b1);
        chk("retire_busy", busy, 3'b010);
        chk("retire_x0", xo(0), 700);
        chk("retire_loc0", lo(0), 0);
        chk("x1_at_179", xo(1), 179);

        apply_alloc(2);
        apply_alloc(3);

        // Pool full with cooldown saturated, then slot1 retires.
        cycn(COOLDOWN, 1'b1, 1'b0);
        chk("full_busy", busy, 3'b111);
        chk("full_pls", spawn_pls, 0);
        rand_val = 13'd7;
        cycn(99, 1'b0, 1'b1);
        chk("x1_at_80", xo(1), 80);
        cyc(1'b0, 1'b1);
        chk("s1_retired", busy, 3'b101);
        chk("s1_retire_x", xo(1), 700);
        chk("s1_retire_loc", lo(1), 0);
        chk("s0_x_600", xo(0), 600);
        chk("s2_x_600", xo(2), 600);
        cyc(1'b0, 1'b0);
        chk("s1_realloc", busy, 3'b111);
        chk("s1_realloc_loc", lo(1), 2);
        chk("s1_realloc_x", xo(1), 700);
        chk("s1_realloc_pls", spawn_pls, 1);
        chk("s0_untouched", xo(0), 600);
        chk("s2_untouched_loc", lo(2), 1);
        chk("step_still_1", step, 1);

        // Free-running spawn + move; model checks each slot transition and
        // the step ramp against the cumulative retirement count.
        prev_lane_m = 2'd2;
        total_ret = 2;
        exp_step = 1;
        for (int c = 0; c < 20000 && total_ret < 40; c++) begin
            pb = busy;
            for (int k = 0; k < NSLOT; k++) px[k] = xo(k);
            sp = exp_step;
            r = 13'($urandom_range(0, 8191));
            rand_val = r;
            exp_lane = 2'(r % 3) + 2'd1;
`ifdef OBSTACLE_LANE_GUARD_EN
            if (exp_lane == prev_lane_m) exp_lane = (prev_lane_m == 2'd3) ? 2'd1 : prev_lane_m + 2'd1;
`endif
            cyc(1'b1, 1'b1);
            allocs = 0;
            for (int k = 0; k < NSLOT; k++) begin
                if (pb[k] && busy[k]) begin
                    chk("move_thresh", (px[k] >= 80 + sp), 1);
                    chk("move_x", xo(k), px[k] - sp);
                end else if (pb[k] && !busy[k]) begin
                    chk("retire_thresh", (px[k] < 80 + sp), 1);
                    chk("ramp_retire_x", xo(k), 700);
                    chk("ramp_retire_loc", lo(k), 0);
                    total_ret++;
                end else if (!pb[k] && busy[k]) begin
                    allocs++;
                    chk("ramp_alloc_x", xo(k), 700);
                    chk("ramp_alloc_loc", lo(k), exp_lane);
                    prev_lane_m = exp_lane;
                end
            end
            chk("ramp_pls", spawn_pls, (allocs == 1));
            exp_step = (1 + total_ret / 8 > 4) ? 4 : 1 + total_ret / 8;
            chk("ramp_step", step, exp_step);
        end
        chk("ramp_budget", (total_ret >= 40), 1);
        chk("step_held_4", step, 4);

        // Hit freezes everything until restart.
        sb = busy;
        sx = slot_x;
        ss = step;
        hit = 1'b1;
        cyc(1'b1, 1'b1);
        hit = 1'b0;
        chk("frozen_state", state_dbg, 2);
        chk("frozen_x_hit", slot_x, sx);
        cycn(20, 1'b1, 1'b1);
        chk("frozen_x", slot_x, sx);
        chk("frozen_busy", busy, sb);
        chk("frozen_step", step, ss);
        game_run = 1'b0;
        cyc(1'b1, 1'b1);
        game_run = 1'b1;
        chk("frozen_no_idle", state_dbg, 2);
        restart = 1'b1;
        cyc(1'b0, 1'b0);
        restart = 1'b0;
        chk("restart_busy", busy, 0);
        chk("restart_step", step, 1);
        chk("restart_state", state_dbg, 0);
        chk("restart_x", slot_x, {10'd700, 10'd700, 10'd700});
        chk("restart_loc", slot_loc, 0);

        // Asynchronous reset in the middle of an allocation.
        cyc(1'b0, 1'b0);
        chk("rerun_state", state_dbg, 1);
        rand_val = 13'd2;
        cycn(COOLDOWN, 1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        chk("pre_reset_pls", spawn_pls, 1);
        chk("pre_reset_loc", lo(0), 3);
        #2;
        RESET = 1'b1;
        #1;
        chk("async_busy", busy, 0);
        chk("async_x", slot_x, {10'd700, 10'd700, 10'd700});
        chk("async_loc", slot_loc, 0);
        chk("async_pls", spawn_pls, 0);
        chk("async_state", state_dbg, 0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
